// File: rtl/l2_trace_dispatcher.sv
// l2_trace_dispatcher: decodes trace records into L2 requests, runs clear/print housekeeping
// and keeps saturating read/write/hit/miss statistics.
module l2_trace_dispatcher #(
  parameter int TAG_BITS = 12,
  parameter int INDEX_BITS = 14,
  parameter int OFFSET_BITS = 6,
  parameter int CNT_W = 32,
  parameter logic [7:0] OP_R = 8'd82,
  parameter logic [7:0] OP_W = 8'd87,
  parameter logic [7:0] OP_M = 8'd77,
  parameter logic [7:0] OP_I = 8'd73
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trace_valid,
  output logic                  trace_ready,
  input  logic [3:0]            trace_cmd,
  input  logic [31:0]           trace_addr,
  output logic                  cache_req,
  output logic [7:0]            cache_op,
  output logic                  cache_snoop,
  output logic [TAG_BITS-1:0]   cache_tag,
  output logic [INDEX_BITS-1:0] cache_index,
  input  logic                  cache_ack,
  input  logic                  cache_hit,
  output logic                  clear_req,
  output logic                  print_req,
  output logic                  cmd_err,
  output logic [CNT_W-1:0]      read_cnt,
  output logic [CNT_W-1:0]      write_cnt,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, CLR, PRT} state_t;
  state_t state_q, state_d;
  logic [7:0] op_q, op_d, dec_op;
  logic snoop_q, snoop_d, dec_snoop, dec_legal;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic [INDEX_BITS-1:0] index_q, index_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] read_cnt_q, read_cnt_d, write_cnt_q, write_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
  always_comb begin
    dec_op = '0;
    dec_snoop = 1'b0;
    dec_legal = 1'b1;
    case (trace_cmd)
      4'd0, 4'd2: dec_op = OP_R;
      4'd1: dec_op = OP_W;
      4'd3: begin dec_op = OP_I; dec_snoop = 1'b1; end
      4'd4: begin dec_op = OP_R; dec_snoop = 1'b1; end
      4'd5: begin dec_op = OP_W; dec_snoop = 1'b1; end
      4'd6: begin dec_op = OP_M; dec_snoop = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    snoop_d = snoop_q;
    tag_d = tag_q;
    index_d = index_q;
    err_d = 1'b0;
    read_cnt_d = read_cnt_q;
    write_cnt_d = write_cnt_q;
    hit_cnt_d = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: if (trace_valid) begin
        if (trace_cmd == 4'd8) state_d = CLR;
        else if (trace_cmd == 4'd9) state_d = PRT;
        else if (dec_legal) begin
          op_d = dec_op;
          snoop_d = dec_snoop;
          tag_d = trace_addr[31 -: TAG_BITS];
          index_d = trace_addr[OFFSET_BITS +: INDEX_BITS];
          state_d = REQ;
        end else err_d = 1'b1;
      end
      // only host-side traffic (non-snoop R/W) is counted
      REQ: if (cache_ack) begin
        state_d = IDLE;
        if (!snoop_q) begin
          read_cnt_d = (op_q == OP_R) ? sat_inc(read_cnt_q) : read_cnt_q;
          write_cnt_d = (op_q == OP_W) ? sat_inc(write_cnt_q) : write_cnt_q;
          hit_cnt_d = cache_hit ? sat_inc(hit_cnt_q) : hit_cnt_q;
          miss_cnt_d = cache_hit ? miss_cnt_q : sat_inc(miss_cnt_q);
        end
      end
      CLR: begin
        state_d = IDLE;
        read_cnt_d = '0;
        write_cnt_d = '0;
        hit_cnt_d = '0;
        miss_cnt_d = '0;
      end
      PRT: state_d = cache_ack ? IDLE : PRT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      snoop_q <= 1'b0;
      tag_q <= '0;
      index_q <= '0;
      err_q <= 1'b0;
      read_cnt_q <= '0;
      write_cnt_q <= '0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      snoop_q <= snoop_d;
      tag_q <= tag_d;
      index_q <= index_d;
      err_q <= err_d;
      read_cnt_q <= read_cnt_d;
      write_cnt_q <= write_cnt_d;
      hit_cnt_q <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  // ready is gated by rst_n so it stays low for the whole reset assertion
  assign trace_ready = rst_n && (state_q == IDLE);
  assign cache_req = (state_q == REQ);
  assign clear_req = (state_q == CLR);
  assign print_req = (state_q == PRT);
  assign cache_op = op_q;
  assign cache_snoop = snoop_q;
  assign cache_tag = tag_q;
  assign cache_index = index_q;
  assign cmd_err = err_q;
  assign read_cnt = read_cnt_q;
  assign write_cnt = write_cnt_q;
  assign hit_cnt = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_l2_trace_dispatcher.sv
// tb_l2_trace_dispatcher: directed plus random trace records checked against a
// transaction-level model of decode, request fields and saturating statistics.
module tb_l2_trace_dispatcher;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst_n = 0, trace_valid = 0, cache_ack = 0, cache_hit = 0;
  logic [3:0] trace_cmd = '0;
  logic [31:0] trace_addr = '0;
  logic trace_ready, cache_req, cache_snoop, clear_req, print_req, cmd_err;
  logic [7:0] cache_op;
  logic [11:0] cache_tag;
  logic [13:0] cache_index;
  logic [CW-1:0] read_cnt, write_cnt, hit_cnt, miss_cnt;
  int checks = 0, failures = 0;
  int m_rd = 0, m_wr = 0, m_hit = 0, m_miss = 0;
  // kind: 0 read, 1 write, 2 snoop op, 3 clear, 4 print, 5 illegal
  int kind_t[16] = '{0, 1, 0, 2, 2, 2, 2, 5, 3, 4, 5, 5, 5, 5, 5, 5};
  int op_t[16] = '{82, 87, 82, 73, 82, 87, 77, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  l2_trace_dispatcher #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_cmd(trace_cmd), .trace_addr(trace_addr), .cache_req(cache_req),
    .cache_op(cache_op), .cache_snoop(cache_snoop), .cache_tag(cache_tag),
    .cache_index(cache_index), .cache_ack(cache_ack), .cache_hit(cache_hit),
    .clear_req(clear_req), .print_req(print_req), .cmd_err(cmd_err),
    .read_cnt(read_cnt), .write_cnt(write_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk_cnt;
    chk("read_cnt", read_cnt, m_rd);
    chk("write_cnt", write_cnt, m_wr);
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
  endtask

  task automatic rec(input logic [3:0] cmd, input logic [31:0] addr, input int dly, input bit hit);
    int n = 0;
    int k = kind_t[cmd];
    while (!trace_ready && n < 20) begin
      tick;
      n++;
    end
    chk("ready_before_accept", trace_ready, 1);
    trace_valid = 1; trace_cmd = cmd; trace_addr = addr;
    tick;
    trace_valid = 0;
    if (k <= 2) begin
      chk("req_after_accept", cache_req, 1);
      chk("op", cache_op, op_t[cmd]);
      chk("snoop", cache_snoop, k == 2);
      chk("tag", cache_tag, addr >> 20);
      chk("index", cache_index, (addr >> 6) & 32'h3fff);
      chk("ready_busy", trace_ready, 0);
      repeat (dly) begin
        tick;
        chk("req_held", cache_req, 1);
      end
      cache_ack = 1; cache_hit = hit;
      tick;
      cache_ack = 0; cache_hit = 0;
      chk("req_drop", cache_req, 0);
      chk("ready_back", trace_ready, 1);
      if (k == 0) m_rd = sat(m_rd);
      if (k == 1) m_wr = sat(m_wr);
      if (k != 2) begin
        if (hit) m_hit = sat(m_hit);
        else m_miss = sat(m_miss);
      end
      chk_cnt;
    end else if (k == 3) begin
      chk("clear_pulse", clear_req, 1);
      chk("clear_ready", trace_ready, 0);
      tick;
      m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
      chk("clear_end", clear_req, 0);
      chk_cnt;
    end else if (k == 4) begin
      repeat (dly) begin
        chk("print_held", print_req, 1);
        tick;
      end
      chk("print_held", print_req, 1);
      cache_ack = 1;
      tick;
      cache_ack = 0;
      chk("print_drop", print_req, 0);
      chk_cnt;
    end else begin
      chk("cmd_err_pulse", cmd_err, 1);
      chk("illegal_no_req", cache_req, 0);
      tick;
      chk("cmd_err_end", cmd_err, 0);
      chk_cnt;
    end
  endtask

  initial begin
    #2;
    chk("rst_ready", trace_ready, 0);
    chk("rst_req", cache_req, 0);
    chk("rst_op", cache_op, 0);
    chk("rst_clear", clear_req, 0);
    chk_cnt;
    @(negedge clk);
    rst_n = 1;
    tick;
    chk("idle_ready", trace_ready, 1);
    rec(4'd0, 32'hABC12345, 2, 1);
    rec(4'd6, 32'h00000040, 1, 0);
    rec(4'd1, 32'h12345678, 0, 0);
    rec(4'd2, 32'hFFFFFFFF, 1, 1);
    rec(4'd0, 32'h00000000, 3, 0);
    rec(4'd8, 32'h0, 0, 0);
    rec(4'd7, 32'hDEADBEEF, 0, 0);
    rec(4'd9, 32'h0, 4, 0);
    rec(4'd0, 32'h5555_5580, 0, 1);
    rec(4'd0, 32'h5555_55BF, 0, 0);
    // reset abandons an outstanding request; a late ack must be ignored
    trace_valid = 1; trace_cmd = 4'd1; trace_addr = 32'hCAFE0000;
    tick;
    trace_valid = 0;
    chk("pre_reset_req", cache_req, 1);
    #2 rst_n = 0;
    #1;
    chk("async_req_drop", cache_req, 0);
    chk("reset_ready", trace_ready, 0);
    chk("reset_op", cache_op, 0);
    m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0;
    chk_cnt;
    @(negedge clk);
    rst_n = 1;
    cache_ack = 1; cache_hit = 1;
    tick;
    cache_ack = 0; cache_hit = 0;
    chk("late_ack_req", cache_req, 0);
    chk("late_ack_ready", trace_ready, 1);
    chk_cnt;
    repeat (17) rec(4'd0, $urandom, 0, 1);
    chk("sat_read", read_cnt, CMAX);
    chk("sat_hit", hit_cnt, CMAX);
    rec(4'd8, 32'h0, 0, 0);
    repeat (80) rec(4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
